request_unit: RTL
=================

REQUEST_UNIT -- requirements
Module: request_unit

Interface
- REQ-001: Parameter CNT_W, default 16, width of the stall-cycle counter.
- REQ-002: Parameter ADDR_HOLD, default 1; when 1, data address capture is enabled as defined in REQ-023.
- REQ-003: CLK  in  1  single clock; all state changes on rising edge.
- REQ-004: nRST  in  1  reset, asynchronous, active-low.
- REQ-005: cu_iREN  in  1  instruction fetch request from control unit.
- REQ-006: cu_dREN  in  1  data read request from control unit (load).
- REQ-007: cu_dWEN  in  1  data write request from control unit (store).
- REQ-008: cu_halt  in  1  halt request from control unit.
- REQ-009: ihit  in  1  instruction memory completed the current fetch.
- REQ-010: dhit  in  1  data memory completed the current read/write.
- REQ-011: alu_addr  in  32  data address computed by ALU.
- REQ-012: imemREN  out  1  instruction memory read enable.
- REQ-013: dmemREN  out  1  data memory read enable.
- REQ-014: dmemWEN  out  1  data memory write enable.
- REQ-015: dmemaddr  out  32  data memory address.
- REQ-016: pc_en  out  1  one-cycle pulse permitting PC/register-file commit.
- REQ-017: halt  out  1  sticky halt indication.
- REQ-018: req_err  out  1  sticky flag: cu_dREN and cu_dWEN seen together.
- REQ-019: stall_cnt  out  CNT_W  cycles spent waiting in DATA state, saturating.

Function
- REQ-020: FSM states: FETCH, DATA, HALTED; state encoding is free.
- REQ-021: FETCH: imemREN = cu_iREN; dmemREN = 0; dmemWEN = 0.
- REQ-022: FETCH, ihit=1, cu_halt=1 -> HALTED next cycle; pc_en = 0; halt has priority over all data requests.
- REQ-023: FETCH, ihit=1, cu_halt=0, cu_dREN or cu_dWEN = 1 -> DATA next cycle; pc_en = 0; latch request type; when ADDR_HOLD=1, also latch alu_addr.
- REQ-024: FETCH, ihit=1, no data request, no halt -> stay in FETCH; pc_en = 1 for that cycle.
- REQ-025: FETCH, ihit=0 -> stay in FETCH; pc_en = 0; dhit ignored.
- REQ-026: DATA: imemREN = 0; dmemREN/dmemWEN driven from the latched request type; exactly one of the two is 1.
- REQ-027: cu_dREN=1 and cu_dWEN=1 together at latch time -> write wins (dmemWEN=1, dmemREN=0); req_err set and held until reset.
- REQ-028: DATA, dhit=0 -> stay in DATA; stall_cnt += 1, saturating at 2^CNT_W-1; ihit ignored.
- REQ-029: DATA, dhit=1 -> FETCH next cycle; pc_en = 1 that cycle; latched request cleared; stall_cnt not incremented.
- REQ-030: dmemaddr = latched address in DATA when ADDR_HOLD=1; otherwise dmemaddr = alu_addr combinationally.
- REQ-031: HALTED: imemREN, dmemREN, dmemWEN, pc_en all 0; halt = 1; state held until nRST.
- REQ-032: cu_halt asserted while in DATA has no effect until the next FETCH ihit.
- REQ-033: pc_en never asserts on two consecutive cycles spanning a FETCH->DATA transition.
- REQ-034: all outputs other than imemREN, pc_en and (ADDR_HOLD=0) dmemaddr are registered or decoded from registered state only.

Reset
- REQ-035: nRST=0 asynchronously forces FETCH, clears latched request, address, halt, req_err and stall_cnt.
- REQ-036: during and immediately after reset: imemREN = cu_iREN, dmemREN = 0, dmemWEN = 0, pc_en = 0, halt = 0, dmemaddr = 0 (ADDR_HOLD=1).
- REQ-037: reset asserted mid-DATA aborts the access: dmemREN/dmemWEN drop in the same cycle without waiting for a clock edge.

Verification
- REQ-038: ALU op: cu_iREN=1, ihit=1 for 3 cycles -> pc_en=1 on each cycle, dmem enables stay 0.
- REQ-039: load: ihit=1 with cu_dREN=1, alu_addr=0x100, then dhit after 3 wait cycles -> dmemREN=1, dmemaddr=0x100 for 4 cycles, stall_cnt=3, pc_en pulses once on the dhit cycle.
- REQ-040: store with cu_dREN=cu_dWEN=1 -> dmemWEN=1, dmemREN=0, req_err=1 held after return to FETCH.
- REQ-041: halt: ihit=1 with cu_halt=1 and cu_dWEN=1 -> HALTED, halt=1, all enables 0 for 10 cycles despite ihit/dhit toggling.
- REQ-042: nRST pulsed low mid-DATA (between edges) -> dmemREN=0 immediately, stall_cnt=0, FETCH after release.
- REQ-043: saturation with CNT_W=4: 20 DATA wait cycles -> stall_cnt=15.

Source files
------------

// File: rtl/request_unit.sv
// Request unit: sequences instruction fetch, one optional data access and halt
// for a single-cycle-issue datapath, gating PC/register-file commit with pc_en.
module request_unit #(
  parameter int CNT_W     = 16,
  parameter bit ADDR_HOLD = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             cu_iREN,
  input  logic             cu_dREN,
  input  logic             cu_dWEN,
  input  logic             cu_halt,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [31:0]      alu_addr,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic [31:0]      dmemaddr,
  output logic             pc_en,
  output logic             halt,
  output logic             req_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic        dren_q;
  logic        dwen_q;
  logic [31:0] addr_q;
  logic        halt_q;
  logic        err_q;
  logic [CNT_W-1:0] cnt_q;

  logic data_req;
  logic fetch_commit;
  logic data_commit;

  assign data_req = cu_dREN | cu_dWEN;

  // A fetch commits only when it carries no follow-on data access or halt.
  assign fetch_commit = (state == FETCH) & ihit & ~cu_halt & ~data_req;
  assign data_commit  = (state == DATA) & dhit;

  // NOTE: the async reset also gates pc_en so no commit can leak out while
  // nRST is low, even though state already reads FETCH during reset.
  assign pc_en   = nRST & (fetch_commit | data_commit);
  assign imemREN = (state == FETCH) & cu_iREN;

  assign dmemREN   = dren_q;
  assign dmemWEN   = dwen_q;
  assign halt      = halt_q;
  assign req_err   = err_q;
  assign stall_cnt = cnt_q;
  assign dmemaddr  = ADDR_HOLD ? addr_q : alu_addr;

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values; the async clear drops the data enables immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= FETCH;
      dren_q <= 1'b0;
      dwen_q <= 1'b0;
      addr_q <= '0;
      halt_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (ihit) begin
            if (cu_halt) begin
              state  <= HALTED;
              halt_q <= 1'b1;
            end else if (data_req) begin
              state  <= DATA;
              // Write wins when both requests arrive together.
              dwen_q <= cu_dWEN;
              dren_q <= cu_dREN & ~cu_dWEN;
              if (ADDR_HOLD) addr_q <= alu_addr;
              if (cu_dREN && cu_dWEN) err_q <= 1'b1;
            end
          end
        end
        DATA: begin
          if (dhit) begin
            state  <= FETCH;
            dren_q <= 1'b0;
            dwen_q <= 1'b0;
            addr_q <= '0;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule
